// File: rtl/axil_cordic.sv
// AXI4-Lite front end for a floating-point CORDIC sin/cos unit, together with the
// cordic_float core it drives. Angles are IEEE-754 single degrees; results are single floats.

module cordic_float (
  input  logic        clk,
  input  logic        ce,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        done,
  output logic [31:0] sin,
  output logic [31:0] cos
);
  localparam int FRAC = 24;                  // fraction bits of the degree accumulator
  localparam int ZW   = 42;                  // covers |angle| < 2^16 degrees plus sign
  localparam logic signed [ZW-1:0] DEG90  = ZW'(90)  <<< FRAC;
  localparam logic signed [ZW-1:0] DEG180 = ZW'(180) <<< FRAC;
  localparam logic signed [ZW-1:0] DEG360 = ZW'(360) <<< FRAC;
  localparam logic signed [31:0]   CORDIC_K  = 32'sd652032874;  // 0.6072529 in Q1.30
  localparam logic [4:0]           LAST_ITER = 5'd23;

  typedef enum logic [1:0] {C_IDLE, C_REDUCE, C_ROT, C_PACK} cstate_t;

  cstate_t               cstate_q;
  logic signed [ZW-1:0]  z_q;
  logic signed [31:0]    x_q, y_q;
  logic [4:0]            iter_q;
  logic                  neg_q;

  // atan(2^-i) in degrees, scaled by 2^FRAC
  function automatic logic signed [ZW-1:0] atan_deg(input logic [4:0] i);
    case (i)
      5'd0:  return ZW'(754974720);
      5'd1:  return ZW'(445687602);
      5'd2:  return ZW'(235489089);
      5'd3:  return ZW'(119537938);
      5'd4:  return ZW'(60000934);
      5'd5:  return ZW'(30029717);
      5'd6:  return ZW'(15018523);
      5'd7:  return ZW'(7509720);
      5'd8:  return ZW'(3754917);
      5'd9:  return ZW'(1877466);
      5'd10: return ZW'(938734);
      5'd11: return ZW'(469367);
      5'd12: return ZW'(234684);
      5'd13: return ZW'(117342);
      5'd14: return ZW'(58671);
      5'd15: return ZW'(29335);
      5'd16: return ZW'(14668);
      5'd17: return ZW'(7334);
      5'd18: return ZW'(3667);
      5'd19: return ZW'(1833);
      5'd20: return ZW'(917);
      5'd21: return ZW'(458);
      5'd22: return ZW'(229);
      5'd23: return ZW'(115);
      default: return '0;
    endcase
  endfunction

  // Zero, denormals, and magnitudes of 2^16 degrees or more (incl. inf/NaN) map to 0.
  function automatic logic signed [ZW-1:0] deg_to_fix(input logic [31:0] f);
    logic [7:0]    e;
    logic [ZW-1:0] mag;
    e   = f[30:23];
    mag = '0;
    if (e != 8'd0 && e <= 8'd142) begin
      if (e >= 8'd126) mag = {{(ZW-24){1'b0}}, 1'b1, f[22:0]} << (e - 8'd126);
      else             mag = {{(ZW-24){1'b0}}, 1'b1, f[22:0]} >> (8'd126 - e);
    end
    return f[31] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic [31:0] fix_to_float(input logic signed [31:0] v);
    logic [31:0] mag, norm;
    int          lead;
    mag  = v[31] ? -v : v;
    lead = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) lead = i;
    if (lead < 0) return '0;
    norm = mag << (31 - lead);
    return {v[31], 8'(lead + 97), norm[30:8]};
  endfunction

  // NOTE: the core datapath deliberately has no reset; the front end only trusts done after
  // it has issued start, so whatever these registers hold at power-up never becomes visible.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (ce) begin
      if (start) begin
        z_q      <= deg_to_fix(angle);
        x_q      <= CORDIC_K;
        y_q      <= '0;
        iter_q   <= '0;
        neg_q    <= 1'b0;
        cstate_q <= C_REDUCE;
      end else begin
        case (cstate_q)
          C_IDLE: ;
          C_REDUCE: begin
            if (z_q > DEG180)       z_q <= z_q - DEG360;
            else if (z_q < -DEG180) z_q <= z_q + DEG360;
            else begin
              // Fold into [-90, 90]; a half-turn negates both results.
              if (z_q > DEG90) begin
                z_q   <= z_q - DEG180;
                neg_q <= 1'b1;
              end else if (z_q < -DEG90) begin
                z_q   <= z_q + DEG180;
                neg_q <= 1'b1;
              end
              cstate_q <= C_ROT;
            end
          end
          C_ROT: begin
            if (z_q[ZW-1]) begin
              x_q <= x_q + (y_q >>> iter_q);
              y_q <= y_q - (x_q >>> iter_q);
              z_q <= z_q + atan_deg(iter_q);
            end else begin
              x_q <= x_q - (y_q >>> iter_q);
              y_q <= y_q + (x_q >>> iter_q);
              z_q <= z_q - atan_deg(iter_q);
            end
            iter_q <= iter_q + 5'd1;
            if (iter_q == LAST_ITER) cstate_q <= C_PACK;
          end
          C_PACK: begin
            cos      <= fix_to_float(neg_q ? -x_q : x_q);
            sin      <= fix_to_float(neg_q ? -y_q : y_q);
            done     <= 1'b1;
            cstate_q <= C_IDLE;
          end
        endcase
      end
    end
  end
endmodule

module axil_cordic #(
  parameter int ADDR_WIDTH = 4,
  parameter int CLK_DIV    = 10
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CALC} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_cnt;
  logic             ce, busy, core_start, core_done;
  logic             aw_w_ready_q, wr_en, start_req, rd_en;
  logic [1:0]       wr_addr;
  logic [31:0]      angle_q, cos_q, sin_q, core_sin, core_cos, rd_mux;
  logic             done_q;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                       div_cnt <= '0;
    else if (div_cnt == CNT_W'(CLK_DIV - 1))  div_cnt <= '0;
    else                                      div_cnt <= div_cnt + 1'b1;
  end
  assign ce = (div_cnt == CNT_W'(CLK_DIV - 1));

  assign wr_addr   = S_AXI_AWADDR[3:2];
  assign wr_en     = aw_w_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign start_req = wr_en & (wr_addr == 2'd0) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign rd_en     = S_AXI_ARREADY & S_AXI_ARVALID;

  // Control FSM: ARM waits for the next ce so the core sees start exactly once.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_ARM;
      ST_ARM:  if (ce)        state_d = ST_CALC;
      ST_CALC: if (core_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    core_start = (state_q == ST_ARM) & ce;
  end

  cordic_float u_core (
    .clk   (S_AXI_ACLK),
    .ce    (ce),
    .start (core_start),
    .angle (angle_q),
    .done  (core_done),
    .sin   (core_sin),
    .cos   (core_cos)
  );

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_w_ready_q  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      angle_q       <= '0;
      cos_q         <= '0;
      sin_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      aw_w_ready_q <= !aw_w_ready_q & S_AXI_AWVALID & S_AXI_WVALID & !S_AXI_BVALID;
      if (wr_en)             S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;

      if (wr_en && wr_addr == 2'd1)
        for (int b = 0; b < 4; b++)
          if (S_AXI_WSTRB[b]) angle_q[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];

      if (start_req && state_q == ST_IDLE) done_q <= 1'b0;
      else if (state_q == ST_CALC && core_done) begin
        done_q <= 1'b1;
        cos_q  <= core_cos;
        sin_q  <= core_sin;
      end

      S_AXI_ARREADY <= !S_AXI_ARREADY & S_AXI_ARVALID & !S_AXI_RVALID;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rd_mux = {15'b0, done_q, 15'b0, busy};
      2'd1: rd_mux = angle_q;
      2'd2: rd_mux = cos_q;
      2'd3: rd_mux = sin_q;
    endcase
  end

  assign S_AXI_AWREADY = aw_w_ready_q;
  assign S_AXI_WREADY  = aw_w_ready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
endmodule

// File: tb/tb_axil_cordic.sv
// Scoreboard bench for axil_cordic: read tasks queue expected data, a negedge monitor
// compares every accepted read beat. Float results are compared with a 1e-4 tolerance.

module tb_axil_cordic;
  localparam int BOUND = 50;

  typedef struct {
    logic [31:0] exp;
    int          kind;   // 0 exact, 1 float within 1e-4, 2 status poll (busy or done)
    int          tag;
    logic [3:0]  addr;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;
  exp_t sb[$];

  axil_cordic dut (
    .S_AXI_ACLK    (aclk),
    .S_AXI_ARESETN (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real m;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -m : m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every read beat accepted by the master is compared against the queue head.
  always @(negedge aclk) begin : monitor
    exp_t e;
    bit   ok;
    real  diff;
    if (rvalid && rready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %08h with no expectation queued", rdata);
      end else begin
        e = sb.pop_front();
        case (e.kind)
          0: ok = (rdata === e.exp);
          1: begin
            diff = f2r(rdata) - f2r(e.exp);
            ok = (diff < 1.0e-4) && (diff > -1.0e-4);
          end
          default: ok = (rdata === 32'h0000_0001) || (rdata === 32'h0001_0000);
        endcase
        ok = ok && (rresp === 2'b00);
        if (!ok) begin
          errors++;
          $display("FAIL rd#%0d addr %0h kind %0d: got %08h resp %0d expected %08h",
                   e.tag, e.addr, e.kind, rdata, rresp, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int n;
    step();
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < BOUND) begin step(); n++; end
    check("awready", {31'b0, awready}, 32'd1);
    check("wready_with_awready", {31'b0, wready}, 32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("awready_one_cycle", {31'b0, awready}, 32'd0);
    check("bvalid", {31'b0, bvalid}, 32'd1);
    check("bresp", {30'b0, bresp}, 32'd0);
    repeat (hold) begin
      step();
      check("bvalid_hold", {31'b0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("bvalid_clear", {31'b0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int kind,
                          input int hold, output logic [31:0] data);
    int   n;
    exp_t e;
    e.exp = exp; e.kind = kind; e.tag = tag_cnt; e.addr = addr;
    tag_cnt++;
    sb.push_back(e);
    step();
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < BOUND) begin step(); n++; end
    check("arready", {31'b0, arready}, 32'd1);
    step();
    arvalid = 1'b0;
    check("rvalid", {31'b0, rvalid}, 32'd1);
    data = rdata;
    repeat (hold) begin
      step();
      check("arready_low_while_rvalid", {31'b0, arready}, 32'd0);
      check("rvalid_hold", {31'b0, rvalid}, 32'd1);
      check("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("rvalid_clear", {31'b0, rvalid}, 32'd0);
  endtask

  task automatic wait_done();
    logic [31:0] d;
    int          n;
    n = 0;
    do begin
      axi_read(4'h0, 32'h0, 2, 0, d);
      n++;
    end while (d !== 32'h0001_0000 && n < 300);
    check("poll_reaches_done", d, 32'h0001_0000);
  endtask

  task automatic run_angle(input logic [31:0] ang, input logic [31:0] exp_cos,
                           input logic [31:0] exp_sin);
    logic [31:0] d;
    axi_write(4'h4, ang, 4'hF, 0);
    axi_write(4'h0, 32'h1, 4'h1, 0);
    axi_read(4'h0, 32'h0000_0001, 0, 0, d);
    wait_done();
    axi_read(4'h0, 32'h0001_0000, 0, 0, d);
    axi_read(4'h8, exp_cos, 1, 0, d);
    axi_read(4'hC, exp_sin, 1, 0, d);
  endtask

  initial begin
    logic [31:0] d;

    // Reset state
    repeat (3) step();
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_bvalid",  {31'b0, bvalid},  32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_rvalid",  {31'b0, rvalid},  32'd0);
    check("rst_rdata",   rdata, 32'd0);
    aresetn = 1'b1;
    for (int a = 0; a < 4; a++) axi_read(4'(a * 4), 32'h0, 0, 0, d);

    // Address without data must not be accepted
    step();
    awaddr = 4'h4; awvalid = 1'b1;
    repeat (5) step();
    check("aw_alone_no_accept", {31'b0, awready}, 32'd0);
    check("aw_alone_no_bvalid", {31'b0, bvalid}, 32'd0);
    awvalid = 1'b0;

    // Byte strobes, and held BREADY / RREADY
    axi_write(4'h4, 32'hFFFF_FFFF, 4'b0011, 5);
    axi_read(4'h4, 32'h0000_FFFF, 0, 5, d);

    // 30 degrees; then writes to COS and CTRL bit0=0 leave everything unchanged
    run_angle(32'h41F0_0000, 32'h3F5D_B3D7, 32'h3F00_0000);
    axi_write(4'h8, 32'h1234_5678, 4'hF, 0);
    axi_write(4'h0, 32'h0, 4'hF, 0);
    axi_read(4'h0, 32'h0001_0000, 0, 0, d);
    axi_read(4'h8, 32'h3F5D_B3D7, 1, 0, d);

    run_angle(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000);

    // 90 degrees with an ANGLE rewrite and a second START while running
    axi_write(4'h4, 32'h42B4_0000, 4'hF, 0);
    axi_write(4'h0, 32'h1, 4'h1, 0);
    axi_read(4'h0, 32'h0000_0001, 0, 0, d);
    axi_write(4'h4, 32'h3F80_0000, 4'hF, 0);
    axi_write(4'h0, 32'h1, 4'h1, 0);
    axi_read(4'h0, 32'h0000_0001, 0, 0, d);
    axi_read(4'h4, 32'h3F80_0000, 0, 0, d);
    wait_done();
    axi_read(4'h8, 32'h0000_0000, 1, 0, d);
    axi_read(4'hC, 32'h3F80_0000, 1, 0, d);

    run_angle(32'hC334_0000, 32'hBF80_0000, 32'h0000_0000);

    // Reset in the middle of a computation
    axi_write(4'h4, 32'h41F0_0000, 4'hF, 0);
    axi_write(4'h0, 32'h1, 4'h1, 0);
    repeat (40) step();
    aresetn = 1'b0;
    repeat (3) step();
    aresetn = 1'b1;
    axi_read(4'h0, 32'h0, 0, 0, d);
    axi_read(4'h4, 32'h0, 0, 0, d);
    axi_read(4'h8, 32'h0, 0, 0, d);

    // A fresh computation after the abort
    run_angle(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000);

    repeat (3) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
